comp_mul_arb: RTL and testbench

Round-robin arbiter and scheduler that shares one `comp_mul_one` complex multiplier among N requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle to the multiplier. A tag FIFO records which requester owns each in-flight operation, and each result is routed back to its owner with a one-hot response strobe. The block sits between the requester engines and the single multiplier instance.

---
 rtl/comp_mul_arb_if.sv | 44 ++++
 rtl/comp_mul_arb.sv | 171 +++++++++++++++++
 tb/tb_comp_mul_arb.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comp_mul_arb_if.sv
// Bundle between the requester engines, the shared complex multiplier and comp_mul_arb.
// The arbiter connects through the slave modport; the requester/multiplier side uses master.
interface comp_mul_arb_if #(
    parameter int N = 4
);
    // A request moves on a rising edge where req_valid[k] & req_ready[k]. Once valid is raised,
    // the requester keeps its operands stable until that edge. req_ready is one-hot or zero.
    // Responses have no backpressure: rsp_valid is a one-cycle strobe that the owner must take.
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_a_r;
    logic [8*N-1:0] req_a_i;
    logic [8*N-1:0] req_b_r;
    logic [8*N-1:0] req_b_i;

    logic [7:0]     m_a_r;
    logic [7:0]     m_a_i;
    logic [7:0]     m_b_r;
    logic [7:0]     m_b_i;
    logic           m_en;
    logic [16:0]    m_o_r;
    logic [16:0]    m_o_i;
    logic           m_o_en;

    logic [N-1:0]   rsp_valid;
    logic [16:0]    rsp_r;
    logic [16:0]    rsp_i;

    modport master (
        output req_valid, req_a_r, req_a_i, req_b_r, req_b_i,
        input  req_ready,
        input  m_a_r, m_a_i, m_b_r, m_b_i, m_en,
        output m_o_r, m_o_i, m_o_en,
        input  rsp_valid, rsp_r, rsp_i
    );

    modport slave (
        input  req_valid, req_a_r, req_a_i, req_b_r, req_b_i,
        output req_ready,
        output m_a_r, m_a_i, m_b_r, m_b_i, m_en,
        input  m_o_r, m_o_i, m_o_en,
        output rsp_valid, rsp_r, rsp_i
    );
endinterface

// File: rtl/comp_mul_arb.sv
// Round-robin scheduler sharing one complex multiplier among N requesters; a tag FIFO
// remembers the owner of every in-flight operation so results are routed back in issue order.
module comp_mul_arb #(
    parameter int N       = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    comp_mul_arb_if.slave                bus,
    output logic                         busy,
    output logic                         err,
    output logic [$clog2(MAX_OUT+1)-1:0] dbg_cnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] tag_q [MAX_OUT];
    logic [PW-1:0] tag_d [MAX_OUT];

    logic [7:0]    m_a_r_q, m_a_r_d;
    logic [7:0]    m_a_i_q, m_a_i_d;
    logic [7:0]    m_b_r_q, m_b_r_d;
    logic [7:0]    m_b_i_q, m_b_i_d;
    logic          m_en_q, m_en_d;
    logic [N-1:0]  rsp_valid_q, rsp_valid_d;
    logic [16:0]   rsp_r_q, rsp_r_d;
    logic [16:0]   rsp_i_q, rsp_i_d;
    logic          err_q, err_d;

    logic [N-1:0]  grant_oh;
    logic [PW-1:0] grant_idx;
    logic          push;
    logic          pop;
    logic          fifo_empty;

    function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
        return (p == FW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grant depends only on registered state and req_valid, never on the result path,
    // so a pop frees a credit that can be granted from the following cycle on.
    always_comb begin
        int            j;
        logic [PW-1:0] idx;
        logic          found;
        j         = 0;
        idx       = '0;
        found     = 1'b0;
        grant_oh  = '0;
        grant_idx = '0;
        if (!rst && (cnt_q < CW'(MAX_OUT))) begin
            for (int i = 0; i < N; i++) begin
                j = int'(rr_ptr_q) + i;
                if (j >= N) begin
                    j = j - N;
                end
                idx = PW'(j);
                if (!found && bus.req_valid[idx]) begin
                    found         = 1'b1;
                    grant_idx     = idx;
                    grant_oh[idx] = 1'b1;
                end
            end
        end
    end

    assign fifo_empty = (cnt_q == '0);
    assign push       = |(bus.req_valid & grant_oh);
    assign pop        = bus.m_o_en && !fifo_empty;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tag_d       = tag_q;
        m_a_r_d     = m_a_r_q;
        m_a_i_d     = m_a_i_q;
        m_b_r_d     = m_b_r_q;
        m_b_i_d     = m_b_i_q;
        m_en_d      = 1'b0;
        rsp_valid_d = '0;
        rsp_r_d     = rsp_r_q;
        rsp_i_d     = rsp_i_q;
        err_d       = err_q;

        if (push) begin
            m_a_r_d         = bus.req_a_r[8*grant_idx +: 8];
            m_a_i_d         = bus.req_a_i[8*grant_idx +: 8];
            m_b_r_d         = bus.req_b_r[8*grant_idx +: 8];
            m_b_i_d         = bus.req_b_i[8*grant_idx +: 8];
            m_en_d          = 1'b1;
            tag_d[wr_ptr_q] = grant_idx;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            rr_ptr_d        = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end

        if (pop) begin
            rsp_valid_d[tag_q[rd_ptr_q]] = 1'b1;
            rsp_r_d                      = bus.m_o_r;
            rsp_i_d                      = bus.m_o_i;
            rd_ptr_d                     = ptr_inc(rd_ptr_q);
        end

        // A result with no owner is dropped; only the sticky flag records it.
        if (bus.m_o_en && fifo_empty) begin
            err_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int k = 0; k < MAX_OUT; k++) begin
                tag_q[k] <= '0;
            end
            m_a_r_q     <= '0;
            m_a_i_q     <= '0;
            m_b_r_q     <= '0;
            m_b_i_q     <= '0;
            m_en_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_r_q     <= '0;
            rsp_i_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tag_q       <= tag_d;
            m_a_r_q     <= m_a_r_d;
            m_a_i_q     <= m_a_i_d;
            m_b_r_q     <= m_b_r_d;
            m_b_i_q     <= m_b_i_d;
            m_en_q      <= m_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r_q     <= rsp_r_d;
            rsp_i_q     <= rsp_i_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready = grant_oh;
    assign bus.m_a_r     = m_a_r_q;
    assign bus.m_a_i     = m_a_i_q;
    assign bus.m_b_r     = m_b_r_q;
    assign bus.m_b_i     = m_b_i_q;
    assign bus.m_en      = m_en_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_r     = rsp_r_q;
    assign bus.rsp_i     = rsp_i_q;

    assign busy    = (cnt_q != '0) | m_en_q;
    assign err     = err_q;
    assign dbg_cnt = cnt_q;
endmodule

// File: tb/tb_comp_mul_arb.sv
// Directed bench for comp_mul_arb with a signed complex-multiplier stub of selectable latency.
module tb_comp_mul_arb;
    localparam int N = 4;
    localparam int W = 38;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        err;
    logic [2:0]  dbg_cnt;

    comp_mul_arb_if #(.N(N)) bus ();

    comp_mul_arb #(.N(N), .MAX_OUT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .err     (err),
        .dbg_cnt (dbg_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // multiplier stub: latency is lat_m1 + 1 cycles
    logic [2:0]         lat_m1;
    logic               force_en;
    logic [7:0]         stub_v;
    logic [16:0]        stub_r [8];
    logic [16:0]        stub_i [8];
    logic signed [16:0] prod_r;
    logic signed [16:0] prod_i;

    assign prod_r = $signed(bus.m_a_r) * $signed(bus.m_b_r) - $signed(bus.m_a_i) * $signed(bus.m_b_i);
    assign prod_i = $signed(bus.m_a_r) * $signed(bus.m_b_i) + $signed(bus.m_a_i) * $signed(bus.m_b_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            stub_v <= '0;
            for (int k = 0; k < 8; k++) begin
                stub_r[k] <= '0;
                stub_i[k] <= '0;
            end
        end else begin
            stub_v    <= {stub_v[6:0], bus.m_en};
            stub_r[0] <= prod_r;
            stub_i[0] <= prod_i;
            for (int k = 1; k < 8; k++) begin
                stub_r[k] <= stub_r[k-1];
                stub_i[k] <= stub_i[k-1];
            end
        end
    end

    assign bus.m_o_r  = stub_r[lat_m1];
    assign bus.m_o_i  = stub_i[lat_m1];
    assign bus.m_o_en = stub_v[lat_m1] | force_en;

    // scoreboard
    int             vectors;
    int             miscompares;
    int             rsp_cnt;
    logic [W-1:0]   exp_q [$];
    logic [W-1:0]   exp_e;
    logic [3:0]     exp_oh;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ops();
        bus.req_a_r = '0;
        bus.req_a_i = '0;
        bus.req_b_r = '0;
        bus.req_b_i = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        force_en    = 1'b0;
        lat_m1      = 3'd1;
        bus.req_valid = '0;
        clear_ops();

        // reset state
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = 4'b1111;
        #1;
        chk("rst_ready", bus.req_ready, 4'b0000);
        bus.req_valid = '0;
        rst = 1'b0;
        #1;
        chk("rst_m_en", bus.m_en, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_cnt", dbg_cnt, 3'd0);

        // single request: requester 1, (3+1i)(3+2i), latency 2
        bus.req_a_r = 32'h0000_0300;
        bus.req_a_i = 32'h0000_0100;
        bus.req_b_r = 32'h0000_0300;
        bus.req_b_i = 32'h0000_0200;
        bus.req_valid = 4'b0010;
        #1;
        chk("single_ready", bus.req_ready, 4'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("single_m_en", bus.m_en, 1'b1);
        chk("single_m_a_r", bus.m_a_r, 8'd3);
        chk("single_m_a_i", bus.m_a_i, 8'd1);
        chk("single_m_b_r", bus.m_b_r, 8'd3);
        chk("single_m_b_i", bus.m_b_i, 8'd2);
        chk("single_cnt1", dbg_cnt, 3'd1);
        chk("single_busy", busy, 1'b1);
        chk("single_ready_off", bus.req_ready, 4'b0000);
        @(negedge clk);
        chk("single_m_en_low", bus.m_en, 1'b0);
        @(negedge clk);
        chk("single_rsp_early", bus.rsp_valid, 4'b0000);
        @(negedge clk);
        chk("single_rsp_valid", bus.rsp_valid, 4'b0010);
        chk("single_rsp_r", bus.rsp_r, 17'd7);
        chk("single_rsp_i", bus.rsp_i, 17'd9);
        chk("single_cnt0", dbg_cnt, 3'd0);
        @(negedge clk);
        chk("single_rsp_off", bus.rsp_valid, 4'b0000);
        chk("single_rsp_hold", bus.rsp_r, 17'd7);
        chk("single_idle", busy, 1'b0);

        // signed result: requester 3, (6+4i)(2+5i)
        bus.req_a_r = 32'h0600_0000;
        bus.req_a_i = 32'h0400_0000;
        bus.req_b_r = 32'h0200_0000;
        bus.req_b_i = 32'h0500_0000;
        bus.req_valid = 4'b1000;
        #1;
        chk("signed_ready", bus.req_ready, 4'b1000);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("signed_rsp_valid", bus.rsp_valid, 4'b1000);
        chk("signed_rsp_r", bus.rsp_r, 17'h1FFF8);
        chk("signed_rsp_i", bus.rsp_i, 17'd38);

        // round-robin: requester k sends ((k+1)+1i)(2+1i) = (2k+1) + (k+3)i
        clear_ops();
        for (int k = 0; k < N; k++) begin
            bus.req_a_r[8*k +: 8] = 8'(k + 1);
            bus.req_a_i[8*k +: 8] = 8'd1;
            bus.req_b_r[8*k +: 8] = 8'd2;
            bus.req_b_i[8*k +: 8] = 8'd1;
        end
        bus.req_valid = 4'b1111;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rr_rst_ready", bus.req_ready, 4'b0000);
        rst = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            if (c == 8) bus.req_valid = '0;
            #1;
            if (c < 8) begin
                exp_oh = 4'b0001 << (c % 4);
                chk($sformatf("rr_grant%0d", c), bus.req_ready, exp_oh);
                exp_q.push_back({exp_oh, 17'(2 * (c % 4) + 1), 17'((c % 4) + 3)});
            end else begin
                chk($sformatf("rr_nogrant%0d", c), bus.req_ready, 4'b0000);
            end
            chk($sformatf("rr_m_en%0d", c), bus.m_en, (c >= 1 && c <= 8) ? 1'b1 : 1'b0);
            if (c >= 4 && c <= 11 && exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                chk($sformatf("rr_rsp_valid%0d", c), bus.rsp_valid, exp_e[37:34]);
                chk($sformatf("rr_rsp_r%0d", c), bus.rsp_r, exp_e[33:17]);
                chk($sformatf("rr_rsp_i%0d", c), bus.rsp_i, exp_e[16:0]);
            end else begin
                chk($sformatf("rr_rsp_off%0d", c), bus.rsp_valid, 4'b0000);
            end
            @(negedge clk);
        end
        chk("rr_queue_empty", exp_q.size(), 0);

        // credit stall: latency 6, requester 0 held valid, result 1+0i each
        lat_m1 = 3'd5;
        clear_ops();
        bus.req_a_r = 32'h0000_0001;
        bus.req_b_r = 32'h0000_0001;
        bus.req_valid = 4'b0001;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rsp_cnt = 0;
        for (int c = 0; c <= 24; c++) begin
            if (c == 9) bus.req_valid = '0;
            #1;
            if (c <= 3 || c == 8) begin
                chk($sformatf("stall_grant%0d", c), bus.req_ready, 4'b0001);
            end else begin
                chk($sformatf("stall_ready%0d", c), bus.req_ready, 4'b0000);
            end
            if (c >= 4 && c <= 7) chk($sformatf("stall_cnt%0d", c), dbg_cnt, 3'd4);
            if (c == 8) chk("stall_cnt_freed", dbg_cnt, 3'd3);
            if (c >= 1 && c <= 12) chk($sformatf("stall_busy%0d", c), busy, 1'b1);
            if (bus.rsp_valid != '0) begin
                rsp_cnt++;
                chk($sformatf("stall_rsp_tag%0d", c), bus.rsp_valid, 4'b0001);
                chk($sformatf("stall_rsp_r%0d", c), bus.rsp_r, 17'd1);
            end
            @(negedge clk);
        end
        chk("stall_rsp_count", rsp_cnt, 5);
        chk("stall_drained_cnt", dbg_cnt, 3'd0);
        chk("stall_drained_busy", busy, 1'b0);

        // unexpected result
        lat_m1 = 3'd1;
        bus.req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("unexp_err_before", err, 1'b0);
        force_en = 1'b1;
        @(negedge clk);
        force_en = 1'b0;
        #1;
        chk("unexp_err", err, 1'b1);
        chk("unexp_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("unexp_cnt", dbg_cnt, 3'd0);
        @(negedge clk);
        chk("unexp_err_sticky", err, 1'b1);
        chk("unexp_rsp_valid2", bus.rsp_valid, 4'b0000);

        // reset mid-flight: three ops from requester 1, then reset
        lat_m1 = 3'd5;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_err_cleared", err, 1'b0);
        rst = 1'b0;
        clear_ops();
        bus.req_a_r = 32'h0000_0302;
        bus.req_b_r = 32'h0000_0503;
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("mid_grant%0d", c), bus.req_ready, 4'b0010);
            @(negedge clk);
        end
        chk("mid_cnt3", dbg_cnt, 3'd3);
        rst = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_m_en", bus.m_en, 1'b0);
        chk("mid_m_a_r", bus.m_a_r, 8'd0);
        chk("mid_m_b_r", bus.m_b_r, 8'd0);
        chk("mid_rsp_valid", bus.rsp_valid, 4'b0000);
        chk("mid_cnt", dbg_cnt, 3'd0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_err", err, 1'b0);
        bus.req_valid = 4'b1111;
        #1;
        chk("mid_regrant", bus.req_ready, 4'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        rsp_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.rsp_valid != '0) begin
                rsp_cnt++;
                chk($sformatf("mid_rsp_tag%0d", c), bus.rsp_valid, 4'b0001);
                chk($sformatf("mid_rsp_r%0d", c), bus.rsp_r, 17'd6);
            end
            chk($sformatf("mid_err%0d", c), err, 1'b0);
            @(negedge clk);
        end
        chk("mid_rsp_count", rsp_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
